// File: rtl/clbp_trig_responder.sv
// Iterative CORDIC sine/cosine responder for the CLBP theta/cos/sin request interface.
// Optional macro TRIG_ROUND_EN: round-half-up when dropping guard bits (default truncates).
module clbp_trig_responder #(
    parameter  int unsigned INT_WIDTH  = 9,
    parameter  int unsigned FRAC_WIDTH = 16,
    parameter  int unsigned ITERS      = 18,
    parameter  int unsigned GUARD      = 3,
    localparam int unsigned W          = INT_WIDTH + FRAC_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] theta,
    input  logic         theta_valid,
    output logic [W-1:0] cos_data,
    output logic         cos_valid,
    output logic [W-1:0] sin_data,
    output logic         sin_valid,
    output logic         busy
);

    localparam int unsigned ZW = W + GUARD;
    localparam int unsigned XW = W + GUARD + 2;
    localparam int unsigned IW = 5;
    localparam int unsigned FG = FRAC_WIDTH + GUARD;

    // Angle constants at FRAC_WIDTH+GUARD (19) fractional bits, rounded from the exact values
    localparam logic signed [ZW-1:0] TWO_PI_G  = ZW'(3294199);
    localparam logic signed [ZW-1:0] PI_G      = ZW'(1647099);
    localparam logic signed [ZW-1:0] HALF_PI_G = ZW'(823550);
    localparam logic signed [ZW-1:0] NPI_G     = -PI_G;
    localparam logic signed [ZW-1:0] NHALF_PI_G = -HALF_PI_G;

    localparam logic signed [XW-1:0] K_G   = XW'(318375);
    localparam logic signed [XW-1:0] ONE_G = XW'(1 << FG);

    localparam logic signed [XW:0] SAT_MAX = (XW+1)'((1 << (W-1)) - 1);
    localparam logic signed [XW:0] SAT_MIN = -SAT_MAX - (XW+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REDUCE,
        S_FOLD,
        S_ITER,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic signed [ZW-1:0] r_z;
    logic signed [XW-1:0] r_x;
    logic signed [XW-1:0] r_y;
    logic [IW-1:0]        r_iter;
    logic                 r_neg;
    logic                 r_busy;
    logic                 r_valid;
    logic [W-1:0]         r_cos;
    logic [W-1:0]         r_sin;

    logic                 w_accept;
    logic                 w_theta_zero;
    logic                 w_last_iter;
    logic signed [XW-1:0] w_x_shr;
    logic signed [XW-1:0] w_y_shr;
    logic signed [ZW-1:0] w_atan;
    logic [W-1:0]         w_cos_nar;
    logic [W-1:0]         w_sin_nar;

    // atan(2^-i) in units of 2^-19 rad
    function automatic logic signed [ZW-1:0] atan_rom(input logic [IW-1:0] idx);
        case (idx)
            5'd0:    atan_rom = ZW'(411775);
            5'd1:    atan_rom = ZW'(243085);
            5'd2:    atan_rom = ZW'(128439);
            5'd3:    atan_rom = ZW'(65198);
            5'd4:    atan_rom = ZW'(32725);
            5'd5:    atan_rom = ZW'(16379);
            5'd6:    atan_rom = ZW'(8191);
            5'd7:    atan_rom = ZW'(4096);
            5'd8:    atan_rom = ZW'(2048);
            5'd9:    atan_rom = ZW'(1024);
            5'd10:   atan_rom = ZW'(512);
            5'd11:   atan_rom = ZW'(256);
            5'd12:   atan_rom = ZW'(128);
            5'd13:   atan_rom = ZW'(64);
            5'd14:   atan_rom = ZW'(32);
            5'd15:   atan_rom = ZW'(16);
            5'd16:   atan_rom = ZW'(8);
            5'd17:   atan_rom = ZW'(4);
            5'd18:   atan_rom = ZW'(2);
            5'd19:   atan_rom = ZW'(1);
            default: atan_rom = ZW'(0);
        endcase
    endfunction

    // Optional negate, drop guard bits, saturate to the output word
    function automatic logic [W-1:0] narrow(input logic signed [XW-1:0] v, input logic neg);
        logic signed [XW:0] t;
        logic signed [XW:0] s;
        t = neg ? -((XW+1)'(v)) : (XW+1)'(v);
`ifdef TRIG_ROUND_EN
        t = t + (XW+1)'(1 << (GUARD-1));
`endif
        s = t >>> GUARD;
        if (s > SAT_MAX) begin
            narrow = SAT_MAX[W-1:0];
        end else if (s < SAT_MIN) begin
            narrow = SAT_MIN[W-1:0];
        end else begin
            narrow = s[W-1:0];
        end
    endfunction

    assign w_accept     = (r_state == S_IDLE) && theta_valid && !r_busy;
    assign w_theta_zero = (theta == '0);
    assign w_last_iter  = (r_iter == IW'(ITERS - 1));
    assign w_x_shr      = r_x >>> r_iter;
    assign w_y_shr      = r_y >>> r_iter;
    assign w_atan       = atan_rom(r_iter);
    assign w_cos_nar    = narrow(r_x, r_neg);
    assign w_sin_nar    = narrow(r_y, r_neg);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_theta_zero ? S_DONE : S_REDUCE;
                end
            end
            S_REDUCE: begin
                if (!(r_z > PI_G) && !(r_z < NPI_G)) begin
                    w_next = S_FOLD;
                end
            end
            S_FOLD:  w_next = S_ITER;
            S_ITER: begin
                if (w_last_iter) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; data reads zero outside the result pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_z     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_iter  <= '0;
            r_neg   <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_cos   <= '0;
            r_sin   <= '0;
        end else begin
            r_valid <= 1'b0;
            r_cos   <= '0;
            r_sin   <= '0;
            if (r_valid) begin
                r_busy <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_z    <= {theta, {GUARD{1'b0}}};
                        r_x    <= ONE_G;
                        r_y    <= '0;
                        r_neg  <= 1'b0;
                        r_busy <= 1'b1;
                    end
                end
                S_REDUCE: begin
                    if (r_z > PI_G) begin
                        r_z <= r_z - TWO_PI_G;
                    end else if (r_z < NPI_G) begin
                        r_z <= r_z + TWO_PI_G;
                    end
                end
                S_FOLD: begin
                    if (r_z > HALF_PI_G) begin
                        r_z   <= r_z - PI_G;
                        r_neg <= 1'b1;
                    end else if (r_z < NHALF_PI_G) begin
                        r_z   <= r_z + PI_G;
                        r_neg <= 1'b1;
                    end else begin
                        r_neg <= 1'b0;
                    end
                    r_x    <= K_G;
                    r_y    <= '0;
                    r_iter <= '0;
                end
                S_ITER: begin
                    if (!r_z[ZW-1]) begin
                        r_x <= r_x - w_y_shr;
                        r_y <= r_y + w_x_shr;
                        r_z <= r_z - w_atan;
                    end else begin
                        r_x <= r_x + w_y_shr;
                        r_y <= r_y - w_x_shr;
                        r_z <= r_z + w_atan;
                    end
                    r_iter <= r_iter + IW'(1);
                end
                S_DONE: begin
                    r_cos   <= w_cos_nar;
                    r_sin   <= w_sin_nar;
                    r_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cos_data  = r_cos;
    assign sin_data  = r_sin;
    assign cos_valid = r_valid;
    assign sin_valid = r_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_clbp_trig_responder.sv
// Scoreboard bench for clbp_trig_responder: real-valued cos/sin model, latency and handshake checks.
module tb_clbp_trig_responder;

    localparam int ITERS = 18;
    localparam real PI_R = 3.14159265358979;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [24:0] theta = '0;
    logic        theta_valid = 1'b0;
    logic [24:0] cos_data;
    logic        cos_valid;
    logic [24:0] sin_data;
    logic        sin_valid;
    logic        busy;

    clbp_trig_responder dut (
        .clk(clk), .rst(rst), .theta(theta), .theta_valid(theta_valid),
        .cos_data(cos_data), .cos_valid(cos_valid),
        .sin_data(sin_data), .sin_valid(sin_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c;
        int s;
        int lat;
        bit exact;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   acc_cyc = 0;

    function automatic int sx(input logic [24:0] v);
        return int'($signed(v));
    endfunction

    // Push the expected result, then present theta for one accepting edge
    task automatic issue(input logic [24:0] th);
        exp_t e;
        real  r;
        real  z;
        int   nred;
        r = real'(sx(th)) / 65536.0;
        z = r;
        nred = 0;
        while (z > PI_R || z < -PI_R) begin
            if (z > PI_R) z = z - 2.0 * PI_R;
            else          z = z + 2.0 * PI_R;
            nred++;
        end
        e.exact = (th == 25'd0);
        e.c     = e.exact ? 65536 : int'($cos(r) * 65536.0);
        e.s     = e.exact ? 0 : int'($sin(r) * 65536.0);
        e.lat   = e.exact ? 1 : nred + ITERS + 3;
        sb.push_back(e);
        @(negedge clk);
        theta       = th;
        theta_valid = 1'b1;
        @(negedge clk);
        theta_valid = 1'b0;
        acc_cyc     = cyc;
    endtask

    // Wait (bounded) for the result pulse and compare against the scoreboard head
    task automatic wait_result(input string name);
        exp_t e;
        int   n;
        int   dc;
        int   ds;
        int   tol;
        bit   got;
        n   = 0;
        got = 1'b0;
        while (n < 200 && !got) begin
            if (cos_valid) got = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: no cos_valid within 200 cycles, required one pulse", name);
            if (sb.size() > 0) void'(sb.pop_front());
            theta_valid = 1'b0;
            return;
        end
        theta_valid = 1'b0;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty at result, required an entry", name);
            return;
        end
        e   = sb.pop_front();
        tol = e.exact ? 0 : 4;
        dc  = sx(cos_data) - e.c;
        ds  = sx(sin_data) - e.s;
        if (dc < 0) dc = -dc;
        if (ds < 0) ds = -ds;
        checks++;
        if (cyc - acc_cyc !== e.lat) begin
            errors++;
            $display("FAIL %s latency got %0d required %0d", name, cyc - acc_cyc, e.lat);
        end
        checks++;
        if (dc > tol) begin
            errors++;
            $display("FAIL %s cos got %0d required %0d +/-%0d", name, sx(cos_data), e.c, tol);
        end
        checks++;
        if (ds > tol) begin
            errors++;
            $display("FAIL %s sin got %0d required %0d +/-%0d", name, sx(sin_data), e.s, tol);
        end
        checks++;
        if (sin_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s result cycle sin_valid=%b busy=%b required 1/1", name, sin_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (cos_valid !== 1'b0 || sin_valid !== 1'b0 || cos_data !== '0 || sin_data !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after pulse valid=%b/%b cos=%h sin=%h busy=%b required all 0",
                     name, cos_valid, sin_valid, cos_data, sin_data, busy);
        end
    endtask

    // Count valid pulses over a window; none are expected
    task automatic expect_quiet(input string name, input int ncyc);
        int pulses;
        pulses = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (cos_valid || sin_valid) pulses++;
        end
        checks++;
        if (pulses != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s stray pulses got %0d busy=%b required 0/0", name, pulses, busy);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (cos_data !== '0 || sin_data !== '0) begin
            errors++;
            $display("FAIL reset data cos=%h sin=%h required 0", cos_data, sin_data);
        end
        checks++;
        if (cos_valid !== 1'b0 || sin_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset flags valid=%b/%b busy=%b required 0", cos_valid, sin_valid, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_zero;
        issue(25'd0);
        wait_result("zero");
    endtask

    task automatic test_quarter;
        issue(25'h000C910);
        wait_result("quarter");
    endtask

    task automatic test_negative;
        issue(25'h1FF36F0);
        wait_result("negative");
    endtask

    task automatic test_fold;
        issue(25'(154416));
        wait_result("fold_3pi4");
        issue(25'(-154416));
        wait_result("fold_neg3pi4");
    endtask

    task automatic test_reduce;
        issue(25'(51472 + 411775));
        wait_result("reduce_1");
        issue(25'(255 * 65536));
        wait_result("reduce_pos255");
        issue(25'(-255 * 65536));
        wait_result("reduce_neg255");
    endtask

    task automatic test_random;
        int v;
        for (int k = 0; k < 6; k++) begin
            v = int'($urandom_range(0, 2 * 16711680)) - 16711680;
            issue(25'(v));
            wait_result("random");
        end
    endtask

    task automatic test_back_to_back;
        issue(25'(34315));
        // Hold a second request through busy, DONE and the result cycle
        theta       = 25'(70000);
        theta_valid = 1'b1;
        wait_result("b2b_first");
        expect_quiet("b2b_dropped", ITERS + 20);
        issue(25'(-34315));
        wait_result("b2b_next");
    endtask

    task automatic test_reset_mid;
        issue(25'h000C910);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (cos_valid !== 1'b0 || cos_data !== '0 || sin_data !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset outputs valid=%b cos=%h sin=%h busy=%b required 0",
                     cos_valid, cos_data, sin_data, busy);
        end
        rst = 1'b0;
        void'(sb.pop_front());
        expect_quiet("midreset_abort", 40);
        issue(25'h000C910);
        wait_result("midreset_next");
    endtask

    initial begin
        test_reset;
        test_zero;
        test_quarter;
        test_negative;
        test_fold;
        test_reduce;
        test_random;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
